cmd_fetch_mem: RTL

//  Parametrised successor to the core's command memory: a host-writable command store plus a prefetch

---
 rtl/cmd_fetch_mem.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cmd_fetch_mem.sv
// -----------------------------------------------------------------------------
// cmd_fetch_mem
//   Host-writable command store with a prefetch queue in front of the core
//   decoder. The host loads commands one WR_WIDTH slice at a time. While run
//   is high, the fetch engine streams commands from fetch pointer fptr into a
//   small queue. The core pops whole commands with valid/ready and can redirect
//   fetch with a one-cycle jump pulse.
//
// Ports
//   clk, rstn     clock, asynchronous active-low reset
//   wr_en         host slice write strobe
//   wr_addr       {command address, slice index}; slice 0 = bits WR_WIDTH-1:0
//   wr_data       slice data
//   run           prefetch enable
//   jump          one-cycle redirect pulse; jump_addr is the new fetch target
//   cmd_out       command at the queue head (0 while cmd_valid is low)
//   cmd_addr      address of cmd_out (0 while cmd_valid is low)
//   cmd_valid     queue head valid
//   cmd_ready     consumer takes the head when cmd_valid & cmd_ready
//   fifo_level    number of entries held in the queue
// -----------------------------------------------------------------------------
module cmd_fetch_mem #(
  parameter int CMD_WIDTH  = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int WR_WIDTH   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic                                             wr_en,
  input  logic [ADDR_WIDTH+$clog2(CMD_WIDTH/WR_WIDTH)-1:0] wr_addr,
  input  logic [WR_WIDTH-1:0]                              wr_data,
  input  logic                                             run,
  input  logic                                             jump,
  input  logic [ADDR_WIDTH-1:0]                            jump_addr,
  output logic [CMD_WIDTH-1:0]                             cmd_out,
  output logic [ADDR_WIDTH-1:0]                            cmd_addr,
  output logic                                             cmd_valid,
  input  logic                                             cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]                      fifo_level
);

  localparam int NSLICE    = CMD_WIDTH / WR_WIDTH;
  localparam int SW        = $clog2(NSLICE);
  localparam int WAW       = ADDR_WIDTH + SW;
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int LW        = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Command store and read port.
  logic [CMD_WIDTH-1:0]  mem [MEM_DEPTH];
  logic [CMD_WIDTH-1:0]  rd_data;
  logic [ADDR_WIDTH-1:0] wr_cmd;
  int unsigned           wr_slice;

  // Fetch engine.
  logic [ADDR_WIDTH-1:0] fptr;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_addr;
  logic                  issue;
  logic [LW:0]           credit;

  // Prefetch queue.
  logic [CMD_WIDTH-1:0]  q_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  push;
  logic                  pop;

  // Slice index is the low SW bits of wr_addr; the command address sits above.
  assign wr_cmd   = wr_addr[WAW-1:SW];
  assign wr_slice = int'(wr_addr) - (int'(wr_cmd) << SW);

  assign pop  = cmd_valid & cmd_ready;
  // A jump discards the read returning this cycle.
  assign push = inflight & ~jump;

  // ---------------------------------------------------------------------------
  // FSM next state and fetch issue decision.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_nxt = state;
    issue     = 1'b0;
    // Slots the queue will be committed to after this edge: current level,
    // less the entry leaving now, plus the read still in flight.
    credit    = {1'b0, level} + (LW+1)'(inflight) - (LW+1)'(pop);

    unique case (state)
      IDLE: if (run)  state_nxt = RUN;
      RUN:  if (!run) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase

    if (state == RUN && !jump && credit < (LW+1)'(FIFO_DEPTH)) begin
      issue = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command store: per-slice write, synchronous read.
  // ---------------------------------------------------------------------------
  // NOTE: storage arrays have no reset. Their contents are only observed once
  // qualified by reset-cleared control state (inflight, level).
  always_ff @(posedge clk) begin
    if (wr_en && wr_slice < NSLICE) begin
      mem[wr_cmd][wr_slice*WR_WIDTH +: WR_WIDTH] <= wr_data;
    end
    // NOTE: non-blocking assignments make a same-edge read see the old word,
    // which gives the read-first behaviour on an address collision.
    if (issue) begin
      rd_data <= mem[fptr];
    end
  end

  // Queue storage: the returning read is written together with its address tag.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= rd_data;
      q_addr[wr_ptr] <= inflight_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      fptr          <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
    end else begin
      state <= state_nxt;
      if (jump) begin
        // Flush takes priority over any push; a pop on this edge is simply lost
        // with the rest of the queue after the consumer has taken it.
        fptr     <= jump_addr;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          fptr          <= fptr + ADDR_WIDTH'(1);
          inflight_addr <= fptr;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(push) - LW'(pop);
      end
    end
  end

  // Head outputs come straight from queue registers and are forced to 0 when
  // the queue is empty, so nothing stale is ever presented.
  assign cmd_valid  = (level != '0);
  assign cmd_out    = cmd_valid ? q_data[rd_ptr] : '0;
  assign cmd_addr   = cmd_valid ? q_addr[rd_ptr] : '0;
  assign fifo_level = level;

endmodule
